cic_comp_decimator: RTL and testbench

CIC_COMP_DECIMATOR -- requirements
Module: cic_comp_decimator

---
 rtl/sdm_pkg.sv | 30 +++
 rtl/q15_round_sat.sv | 29 ++
 rtl/cic_comp_decimator.sv | 123 ++++++++++++
 tb/tb_cic_comp_decimator.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/sdm_pkg.sv
// Shared definitions for the CIC compensation decimator: coefficients,
// accumulator/Q15 limits and the controller state type.
package sdm_pkg;

    localparam int ACC_W     = 40;
    localparam int Q15_MAX   = 32767;
    localparam int Q15_MIN   = -32768;
    localparam int BUF_DEPTH = 32;
    localparam int MAX_TAPS  = 30;

    // Q15 compensator taps. The first 16 are the default filter (sum > 1.0, so
    // full-scale DC needs saturation); the tail is only used for longer filters.
    localparam logic signed [15:0] COMP_COEFFS [MAX_TAPS] = '{
        -16'sd120,  16'sd251,   -16'sd402,  16'sd655,
        -16'sd1030, 16'sd1587,  -16'sd2460, 16'sd4101,
        16'sd28000, 16'sd4101,  -16'sd2460, 16'sd1587,
        -16'sd1030, 16'sd655,   -16'sd402,  16'sd251,
        16'sd87,    -16'sd45,   16'sd23,    -16'sd12,
        16'sd6,     -16'sd3,    16'sd1,     16'sd0,
        16'sd0,     16'sd0,     16'sd0,     16'sd0,
        16'sd0,     16'sd0
    };

    typedef enum logic [1:0] {
        StIdle,
        StMac,
        StRound
    } state_e;

endpackage

// File: rtl/q15_round_sat.sv
// Round-half-up from the Q30 accumulator to Q15, then saturate to 16 bits.
module q15_round_sat
    import sdm_pkg::*;
(
    input  logic signed [ACC_W-1:0] acc,
    output logic signed [15:0]      q
);

    localparam logic signed [ACC_W-1:0] HALF_LSB = ACC_W'(16384);
    localparam logic signed [ACC_W-1:0] SAT_MAX  = ACC_W'(Q15_MAX);
    localparam logic signed [ACC_W-1:0] SAT_MIN  = ACC_W'(Q15_MIN);

    logic signed [ACC_W-1:0] biased;
    logic signed [ACC_W-1:0] shifted;

    // Add half an output LSB, arithmetic shift, clamp to the Q15 range
    always_comb begin
        biased  = acc + HALF_LSB;
        shifted = biased >>> 15;
        if (shifted > SAT_MAX) begin
            q = SAT_MAX[15:0];
        end else if (shifted < SAT_MIN) begin
            q = SAT_MIN[15:0];
        end else begin
            q = shifted[15:0];
        end
    end

endmodule

// File: rtl/cic_comp_decimator.sv
// CIC compensation FIR with decimation: samples land in a 32-entry circular
// buffer; every DECIMATION_FACTOR-th sample starts a serial MAC over NUM_TAPS
// taps, followed by one rounding cycle that emits the output.
module cic_comp_decimator
    import sdm_pkg::*;
#(
    parameter int unsigned NUM_TAPS          = 16,
    parameter int unsigned DECIMATION_FACTOR = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               valid_in,
    input  logic signed [15:0] data_in,
    output logic               valid_out,
    output logic signed [15:0] data_out,
    output logic               busy,
    output logic               overrun,
    input  logic               overrun_clr
);

    logic signed [15:0]      sample_mem_q [BUF_DEPTH];
    logic [4:0]              wr_ptr_q;
    logic [2:0]              phase_q;
    logic [4:0]              base_q;
    logic [4:0]              tap_q;
    logic [4:0]              rd_idx;
    logic signed [ACC_W-1:0] acc_q;
    logic signed [31:0]      product;
    logic signed [15:0]      rounded;
    logic signed [15:0]      data_out_q;
    logic                    valid_out_q;
    logic                    overrun_q;
    logic                    trigger;
    logic                    overrun_set;
    logic                    mac_last;
    state_e                  state_q, state_d;

    assign trigger     = valid_in && (phase_q == 3'(DECIMATION_FACTOR - 1));
    assign overrun_set = trigger && (state_q != StIdle);
    assign mac_last    = (tap_q == 5'(NUM_TAPS - 1));
    // Reads trail the write pointer, so writes during MAC never reach live taps
    assign rd_idx      = base_q - tap_q;
    assign product     = 32'(COMP_COEFFS[tap_q]) * 32'(sample_mem_q[rd_idx]);

    assign valid_out = valid_out_q;
    assign data_out  = data_out_q;
    assign overrun   = overrun_q;
    assign busy      = (state_q != StIdle);

    q15_round_sat u_round_sat (
        .acc (acc_q),
        .q   (rounded)
    );

    // Sample capture and decimation phase, independent of the controller state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                sample_mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            phase_q  <= '0;
        end else if (valid_in) begin
            sample_mem_q[wr_ptr_q] <= data_in;
            wr_ptr_q               <= wr_ptr_q + 5'd1;
            phase_q                <= trigger ? 3'd0 : phase_q + 3'd1;
        end
    end

    // Next-state logic; unused encodings fall back to idle
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (trigger)  state_d = StMac;
            StMac:   if (mac_last) state_d = StRound;
            StRound: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Controller state, MAC datapath and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            base_q      <= '0;
            tap_q       <= '0;
            acc_q       <= '0;
            data_out_q  <= '0;
            valid_out_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            valid_out_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (trigger) begin
                        base_q <= wr_ptr_q;
                        tap_q  <= '0;
                        acc_q  <= '0;
                    end
                end
                StMac: begin
                    acc_q <= acc_q + ACC_W'(product);
                    tap_q <= tap_q + 5'd1;
                end
                StRound: begin
                    data_out_q  <= rounded;
                    valid_out_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Sticky overrun; a new event in the clear cycle takes priority
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= overrun_set | (overrun_q & ~overrun_clr);
        end
    end

endmodule

// File: tb/tb_cic_comp_decimator.sv
// Directed bench for cic_comp_decimator (NUM_TAPS=16, DECIMATION_FACTOR=2).
module tb_cic_comp_decimator;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               valid_in = 1'b0;
    logic signed [15:0] data_in = '0;
    logic               valid_out;
    logic signed [15:0] data_out;
    logic               busy;
    logic               overrun;
    logic               overrun_clr = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;
    int out_q[$];

    // round(h[odd]/2) for the default taps, then zeros past the filter length
    int imp_exp[10] = '{126, 328, 794, 2051, 2051, 794, 328, 126, 0, 0};

    cic_comp_decimator #(
        .NUM_TAPS          (16),
        .DECIMATION_FACTOR (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .valid_in    (valid_in),
        .data_in     (data_in),
        .valid_out   (valid_out),
        .data_out    (data_out),
        .busy        (busy),
        .overrun     (overrun),
        .overrun_clr (overrun_clr)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!reset && valid_out) out_q.push_back(int'(data_out));
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Leaves the bench at a negedge with reset released and queue empty
    task automatic do_reset();
        reset       = 1'b1;
        valid_in    = 1'b0;
        overrun_clr = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        out_q.delete();
    endtask

    // One-cycle valid_in pulse; next pulse may start 'gap' cycles later
    task automatic feed(input int value, input int gap);
        valid_in = 1'b1;
        data_in  = 16'(value);
        @(negedge clk);
        valid_in = 1'b0;
        repeat (gap - 1) @(negedge clk);
    endtask

    initial begin
        int neg_cnt;
        int first_vo;
        int vo_cnt;
        int busy_cnt;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_valid_out", int'(valid_out), 0);
        check("rst_data_out", int'(data_out), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_overrun", int'(overrun), 0);
        reset = 1'b0;

        // Impulse response
        feed(16384, 20);
        for (int i = 1; i < 20; i++) feed(0, 20);
        repeat (5) @(negedge clk);
        check("imp_count", out_q.size(), 10);
        for (int i = 0; i < 10; i++) begin
            check($sformatf("imp_out%0d", i), (i < out_q.size()) ? out_q[i] : -99999,
                  imp_exp[i]);
        end
        check("imp_overrun", int'(overrun), 0);

        // Latency and busy width
        do_reset();
        feed(0, 5);
        valid_in = 1'b1;
        data_in  = '0;
        @(posedge clk);
        first_vo = -1;
        vo_cnt   = 0;
        busy_cnt = 0;
        for (int i = 1; i <= 25; i++) begin
            @(negedge clk);
            if (i == 1) valid_in = 1'b0;
            if (busy) busy_cnt++;
            if (valid_out) begin
                vo_cnt++;
                if (first_vo < 0) first_vo = i;
            end
        end
        check("lat_vo_cycle", first_vo, 18);
        check("lat_vo_pulses", vo_cnt, 1);
        check("lat_busy_cycles", busy_cnt, 17);

        // DC positive saturation at minimum legal trigger spacing (18)
        do_reset();
        for (int i = 0; i < 32; i++) feed(32767, 9);
        repeat (20) @(negedge clk);
        neg_cnt = 0;
        foreach (out_q[i]) if (out_q[i] < 0) neg_cnt++;
        check("dcp_count", out_q.size(), 16);
        check("dcp_last", (out_q.size() > 0) ? out_q[$] : 0, 32767);
        check("dcp_no_wrap", neg_cnt, 0);
        check("dcp_overrun", int'(overrun), 0);

        // DC negative saturation
        do_reset();
        for (int i = 0; i < 32; i++) feed(-32768, 9);
        repeat (20) @(negedge clk);
        neg_cnt = 0;
        foreach (out_q[i]) if (out_q[i] > 0) neg_cnt++;
        check("dcn_count", out_q.size(), 16);
        check("dcn_last", (out_q.size() > 0) ? out_q[$] : 0, -32768);
        check("dcn_no_wrap", neg_cnt, 0);
        check("dcn_overrun", int'(overrun), 0);

        // Overrun with valid_in held high
        do_reset();
        valid_in = 1'b1;
        data_in  = '0;
        @(negedge clk);
        check("ovr_busy_pre", int'(busy), 0);
        @(negedge clk);
        check("ovr_busy_trig1", int'(busy), 1);
        check("ovr_after_trig1", int'(overrun), 0);
        @(negedge clk);
        @(negedge clk);
        check("ovr_after_trig2", int'(overrun), 1);
        valid_in = 1'b0;
        repeat (20) @(negedge clk);
        check("ovr_sticky", int'(overrun), 1);
        check("ovr_one_result", out_q.size(), 1);
        overrun_clr = 1'b1;
        @(negedge clk);
        overrun_clr = 1'b0;
        check("ovr_cleared", int'(overrun), 0);
        valid_in = 1'b1;
        repeat (3) @(negedge clk);
        overrun_clr = 1'b1;
        @(negedge clk);
        check("ovr_set_wins", int'(overrun), 1);
        valid_in    = 1'b0;
        overrun_clr = 1'b0;
        repeat (20) @(negedge clk);

        // Trigger landing in the ROUND cycle is an overrun
        do_reset();
        feed(0, 1);
        feed(0, 16);
        feed(0, 1);
        feed(0, 1);
        check("round_trig_overrun", int'(overrun), 1);
        repeat (20) @(negedge clk);

        // Reset five cycles into MAC
        do_reset();
        feed(16384, 1);
        feed(16384, 20);
        check("mid_pre_count", out_q.size(), 1);
        check("mid_pre_value", (out_q.size() > 0) ? out_q[0] : 0, 66);
        out_q.delete();
        for (int i = 0; i < 4; i++) feed(0, 1);
        check("mid_busy", int'(busy), 1);
        check("mid_overrun", int'(overrun), 1);
        repeat (3) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_valid_out", int'(valid_out), 0);
        check("mid_rst_data_out", int'(data_out), 0);
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_overrun", int'(overrun), 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        out_q.delete();
        repeat (30) @(negedge clk);
        check("mid_no_stray_out", out_q.size(), 0);
        for (int i = 0; i < 4; i++) feed(0, 20);
        check("mid_zero_count", out_q.size(), 2);
        foreach (out_q[i]) check($sformatf("mid_zero_out%0d", i), out_q[i], 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
